// File: rtl/axi4s_if.sv
// AXI4-Stream bundle carrying the subset of signals used by the capture sink.
interface axi4s_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_capture_sink.sv
// AXI4-Stream capture sink: logs accepted beats into a simple dual-port RAM with
// wrap or stop-on-full modes, rotating backpressure, counters and registered readback.
module axis_capture_sink #(
  parameter int         DATA_WIDTH    = 32,
  parameter int         RAM_DEPTH     = 64,
  parameter bit         STOP_ON_FULL  = 1'b0,
  parameter logic [3:0] READY_PATTERN = 4'b1111,
  localparam int        AW            = $clog2(RAM_DEPTH)
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  axi4s_if.slave                AXIS_PORT,
  input  logic                  CLEAR,
  input  logic [AW-1:0]         RD_ADDR,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  RD_LAST,
  output logic [AW-1:0]         WR_PTR,
  output logic [31:0]           BEAT_COUNT,
  output logic [15:0]           PKT_COUNT,
  output logic                  FULL,
  output logic                  WRAPPED
);

  logic                  tready_reg, tready_next;
  logic [3:0]            pattern_reg, pattern_next;
  logic [AW-1:0]         wr_ptr_reg, wr_ptr_next;
  logic [31:0]           beat_count_reg, beat_count_next;
  logic [15:0]           pkt_count_reg, pkt_count_next;
  logic                  full_reg, full_next;
  logic                  wrapped_reg, wrapped_next;
  logic                  accept;
  logic                  last_row;
  logic [DATA_WIDTH:0]   mem [RAM_DEPTH];
  logic [DATA_WIDTH:0]   rd_word_reg;

  // CLEAR and reset both veto a beat even when tready was already high.
  assign accept   = ARESETN & AXIS_PORT.tvalid & tready_reg & ~CLEAR;
  assign last_row = (wr_ptr_reg == AW'(RAM_DEPTH - 1));

  always_comb begin
    pattern_next    = {pattern_reg[0], pattern_reg[3:1]};
    wr_ptr_next     = wr_ptr_reg;
    beat_count_next = beat_count_reg;
    pkt_count_next  = pkt_count_reg;
    full_next       = full_reg;
    wrapped_next    = wrapped_reg;
    if (CLEAR) begin
      pattern_next    = READY_PATTERN;
      wr_ptr_next     = '0;
      beat_count_next = '0;
      pkt_count_next  = '0;
      full_next       = 1'b0;
      wrapped_next    = 1'b0;
    end else if (accept) begin
      wr_ptr_next     = wr_ptr_reg + 1'b1;
      beat_count_next = beat_count_reg + 32'd1;
      if (AXIS_PORT.tlast && (pkt_count_reg != 16'hFFFF)) begin
        pkt_count_next = pkt_count_reg + 16'd1;
      end
      if (last_row) begin
        if (STOP_ON_FULL) begin
          full_next = 1'b1;
        end else begin
          wrapped_next = 1'b1;
        end
      end
    end
    tready_next = pattern_reg[0] & ~(STOP_ON_FULL & full_next) & ~CLEAR;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      tready_reg     <= 1'b0;
      pattern_reg    <= READY_PATTERN;
      wr_ptr_reg     <= '0;
      beat_count_reg <= '0;
      pkt_count_reg  <= '0;
      full_reg       <= 1'b0;
      wrapped_reg    <= 1'b0;
    end else begin
      tready_reg     <= tready_next;
      pattern_reg    <= pattern_next;
      wr_ptr_reg     <= wr_ptr_next;
      beat_count_reg <= beat_count_next;
      pkt_count_reg  <= pkt_count_next;
      full_reg       <= full_next;
      wrapped_reg    <= wrapped_next;
    end
  end

  // Storage has no reset so it maps onto block RAM; the read port is read-before-write.
  always_ff @(posedge ACLK) begin
    if (accept) begin
      mem[wr_ptr_reg] <= {AXIS_PORT.tlast, AXIS_PORT.tdata};
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      rd_word_reg <= '0;
    end else begin
      rd_word_reg <= mem[RD_ADDR];
    end
  end

  assign AXIS_PORT.tready = tready_reg;
  assign RD_DATA          = rd_word_reg[DATA_WIDTH-1:0];
  assign RD_LAST          = rd_word_reg[DATA_WIDTH];
  assign WR_PTR           = wr_ptr_reg;
  assign BEAT_COUNT       = beat_count_reg;
  assign PKT_COUNT        = pkt_count_reg;
  assign FULL             = full_reg;
  assign WRAPPED          = wrapped_reg;

endmodule

// File: doc/axis_capture_sink.md
Name: axis_capture_sink

Overview:
Parametrised successor to the single-mode AXI4-Stream data sink: a capture buffer that logs every accepted beat (data + tlast) into an internal RAM. Adds selectable wrap/stop-on-full modes, a programmable backpressure pattern, packet counting, a soft clear and a synchronous readback port. Used as the terminal slave in stream testbenches and FPGA debug builds, read back by the bench or a register wrapper.

Parameters:
DATA_WIDTH, 32, width of tdata and of each stored word
RAM_DEPTH, 64, number of stored entries; power of two, >= 2
STOP_ON_FULL, 0, 0 = circular (overwrite oldest), 1 = capture once, then hold tready low
READY_PATTERN, 4'b1111, 4-bit rotating tready-enable mask; bit 0 used first; 4'b1111 = never throttle
AW, $clog2(RAM_DEPTH), derived address width (localparam, not overridable)

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESETN  in  1  synchronous active-low reset
AXIS_PORT  axi4s_if.slave  -  stream input; uses tvalid, tready (driven), tdata[DATA_WIDTH-1:0], tlast
CLEAR  in  1  synchronous soft clear pulse
RD_ADDR  in  AW  readback row address
RD_DATA  out  DATA_WIDTH  stored word at RD_ADDR, 1-cycle latency
RD_LAST  out  1  stored tlast at RD_ADDR, 1-cycle latency
WR_PTR  out  AW  next row to be written
BEAT_COUNT  out  32  total accepted beats since reset/clear, wraps mod 2^32
PKT_COUNT  out  16  accepted beats with tlast=1, saturates at 16'hFFFF
FULL  out  1  mode 1: RAM_DEPTH beats stored; mode 0: always 0
WRAPPED  out  1  mode 0: sticky, set when WR_PTR wraps from RAM_DEPTH-1 to 0; mode 1: always 0

Behaviour:
- Reset (ARESETN=0 at edge): tready=0, WR_PTR=0, BEAT_COUNT=0, PKT_COUNT=0, FULL=0, WRAPPED=0, RD_DATA=0, RD_LAST=0, pattern register = READY_PATTERN. RAM contents are not reset.
- Reset mid-transfer: an asserted tvalid during reset is not accepted; tready is 0 the cycle after reset release, so the first possible acceptance is 2 edges after release.
- tready is registered: tready_next = pattern[0] & ~(STOP_ON_FULL & full_next) & ~CLEAR. The pattern rotates right by 1 every non-reset cycle, independent of traffic. tready does not depend on tvalid.
- Transfer = tvalid & tready at a rising edge. On transfer: ram[WR_PTR] <= {tlast, tdata}; WR_PTR += 1 (mod RAM_DEPTH); BEAT_COUNT += 1; PKT_COUNT += tlast (saturating).
- Mode 0 wrap: a write at row RAM_DEPTH-1 sets WR_PTR=0 and WRAPPED=1 (sticky until reset/CLEAR). Data is overwritten oldest-first.
- Mode 1 full: the write at row RAM_DEPTH-1 sets FULL=1. WR_PTR wraps to 0 but no further writes occur. tready is 0 in the cycle after the filling edge and stays 0 until CLEAR or reset.
- CLEAR (sync, any length): on the edge it is sampled, WR_PTR, BEAT_COUNT, PKT_COUNT, FULL and WRAPPED go to 0, and the pattern reloads. If a transfer coincides with CLEAR, CLEAR wins: the beat is dropped (not written, not counted). tready is 0 the cycle after any CLEAR cycle. RAM is not erased.
- Readback: RD_DATA/RD_LAST <= ram[RD_ADDR] each edge (registered, 1 cycle). A same-cycle write to RD_ADDR returns the old content (read-before-write). This maps to a simple dual-port BRAM.
- No combinational path from AXIS_PORT inputs to any output.

Test Plan:
- Reset then 10 beats, tvalid held high, pattern 4'b1111, tdata=0x100+i, tlast on beat 4 and 9 -> tready=1 from 2nd edge after release; WR_PTR=10, BEAT_COUNT=10, PKT_COUNT=2; RD_ADDR=4 gives RD_DATA=0x104, RD_LAST=1 one cycle later.
- Mode 0, RAM_DEPTH=8, 11 beats of data i -> WRAPPED=1 after 8th beat; WR_PTR=3; rows 0..2 = 8,9,10, row 3 = 3; BEAT_COUNT=11.
- Mode 1, RAM_DEPTH=8, tvalid held for 12 cycles -> FULL=1 after 8th transfer, tready=0 afterwards, BEAT_COUNT=8; CLEAR pulse -> counters 0, FULL=0, tready back to 1 two edges later.
- READY_PATTERN=4'b0101, tvalid held 16 cycles -> tready alternates 1/0; exactly 8 transfers; stored data has no gaps or duplicates.
- CLEAR asserted on the same edge as a transfer (tdata=0xDEAD) -> beat dropped, BEAT_COUNT=0, WR_PTR=0, and the next accepted beat is written to row 0.
- ARESETN pulled low mid-burst after 5 beats, held 2 cycles -> all outputs at reset values; the post-release burst restarts at row 0; PKT_COUNT saturation checked with a forced 65537 tlast beats -> 16'hFFFF.
